// File: rtl/countdown_timer.sv
// Loadable down-counter: decrements once per prescaled tick, pulses done on expiry,
// with optional auto-reload for periodic operation.
module countdown_timer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  reload_en,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [WIDTH-1:0]      r_count;
  logic [WIDTH-1:0]      r_reload;
  logic [PRESCALE_W-1:0] r_pc;
  logic [PRESCALE_W-1:0] r_div;
  logic                  r_mode;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tick;
  logic                  w_last;

  // Floor-at-zero decrement so the count can never wrap.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  assign w_tick = (r_pc == r_div);
  assign w_last = (r_count <= CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_pc     <= '0;
      r_div    <= '0;
      r_mode   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_pc    <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (load_val != '0) begin
                r_count  <= load_val;
                r_reload <= load_val;
                r_div    <= prescale;
                r_mode   <= reload_en;
                r_pc     <= '0;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end else begin
                r_count <= '0;
                r_done  <= 1'b1;
              end
            end
          end
          S_RUN, S_PAUSED: begin
            // A start here is ignored; a low pause in PAUSED resumes and ticks in the same cycle.
            if (pause) begin
              r_state <= S_PAUSED;
            end else begin
              r_state <= S_RUN;
              if (w_tick) begin
                r_pc <= '0;
                if (!w_last) begin
                  r_count <= sat_dec(r_count);
                end else if (r_mode) begin
                  r_count <= r_reload;
                  r_done  <= 1'b1;
                end else begin
                  r_count <= '0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end else begin
                r_pc <= r_pc + PC_ONE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against count/busy/done.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic [7:0] prescale;
  logic       reload_en;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       done;

  countdown_timer #(.WIDTH(4), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .prescale(prescale),
    .reload_en(reload_en), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .done(done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic       bsy;
    logic       dn;
    int         id;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   tid    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk = n_chk + 1;
      if (e.cyc != cyc || count !== e.cnt || busy !== e.bsy || done !== e.dn) begin
        n_fail = n_fail + 1;
        $display("FAIL tst%0d cyc%0d: got count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b (for cyc%0d)",
                 e.id, cyc, count, busy, done, e.cnt, e.bsy, e.dn, e.cyc);
      end
    end
  end

  // Queue the expected outputs after the coming edge, advance one cycle, drop one-cycle requests.
  task automatic chk(input logic [3:0] ec, input logic eb, input logic ed);
    q.push_back('{cyc + 1, ec, eb, ed, tid});
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic go(input logic [3:0] lv, input logic [7:0] ps, input logic re);
    load_val  = lv;
    prescale  = ps;
    reload_en = re;
    start     = 1'b1;
  endtask

  logic [3:0] per_cnt [9] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd3};

  initial begin
    rst = 1'b1; start = 1'b0; load_val = '0; prescale = '0;
    reload_en = 1'b0; pause = 1'b0; abort = 1'b0;

    tid = 0;
    chk(0, 0, 0);
    chk(0, 0, 0);
    rst = 1'b0;

    // one-shot, no prescale
    tid = 1;
    go(4, 0, 0);
    chk(4, 1, 0); chk(3, 1, 0); chk(2, 1, 0); chk(1, 1, 0);
    chk(0, 0, 1); chk(0, 0, 0);

    // prescale 2, periodic; config inputs wiggled mid-run must be ignored
    tid = 2;
    go(3, 2, 1);
    chk(3, 1, 0);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 9; k++) begin
        if (p == 1 && k == 0) begin
          load_val = 9; prescale = 0; reload_en = 0;
        end
        chk(per_cnt[k], 1'b1, (k == 8));
      end
    end
    abort = 1'b1;
    chk(0, 0, 0);
    chk(0, 0, 0);

    // pause for 5 cycles at count 4
    tid = 3;
    go(6, 0, 0);
    chk(6, 1, 0); chk(5, 1, 0); chk(4, 1, 0);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) chk(4, 1, 0);
    pause = 1'b0;
    chk(3, 1, 0); chk(2, 1, 0); chk(1, 1, 0); chk(0, 0, 1); chk(0, 0, 0);

    // abort and start together during RUN
    tid = 4;
    go(5, 0, 0);
    chk(5, 1, 0); chk(4, 1, 0);
    go(9, 0, 0);
    abort = 1'b1;
    chk(0, 0, 0); chk(0, 0, 0);

    // abort on the expiry tick
    tid = 5;
    go(2, 0, 0);
    chk(2, 1, 0); chk(1, 1, 0);
    abort = 1'b1;
    chk(0, 0, 0); chk(0, 0, 0);

    // zero load: lone done pulse, never busy
    tid = 6;
    go(0, 0, 0);
    chk(0, 0, 1); chk(0, 0, 0);

    // start during RUN ignored
    tid = 7;
    go(5, 0, 0);
    chk(5, 1, 0); chk(4, 1, 0);
    go(9, 0, 0);
    chk(3, 1, 0); chk(2, 1, 0); chk(1, 1, 0); chk(0, 0, 1); chk(0, 0, 0);

    // pause coincident with expiry tick defers done
    tid = 8;
    go(1, 0, 0);
    chk(1, 1, 0);
    pause = 1'b1;
    chk(1, 1, 0); chk(1, 1, 0);
    pause = 1'b0;
    chk(0, 0, 1); chk(0, 0, 0);

    // reset mid-count overrides a concurrent start
    tid = 9;
    go(7, 0, 0);
    chk(7, 1, 0); chk(6, 1, 0); chk(5, 1, 0);
    rst = 1'b1;
    go(3, 0, 0);
    q.push_back('{cyc + 1, 4'd0, 1'b0, 1'b0, tid});
    @(posedge clk); #1;
    chk(0, 0, 0);
    rst = 1'b0;
    chk(0, 0, 0);

    // let the monitor drain, bounded
    for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
